// File: rtl/noc_pkg.sv
// Shared NoC definitions: flit type encodings, injector FSM states and
// head-flit field offsets. The router decodes head flits with the same helpers.
package noc_pkg;

  typedef enum logic [1:0] {
    FT_BODY      = 2'b00,
    FT_HEAD      = 2'b01,
    FT_TAIL      = 2'b10,
    FT_HEAD_TAIL = 2'b11
  } flit_type_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_HEAD,
    ST_BODY
  } inj_state_t;

  // Head layout, MSB first: dest_x, dest_y, src_x, src_y, len
  function automatic int hdr_w(input int cw, input int lw);
    return 4 * cw + lw;
  endfunction

  function automatic int off_len(input int cw, input int lw);
    return 0 * cw + 0 * lw;
  endfunction

  function automatic int off_src_y(input int cw, input int lw);
    return 0 * cw + lw;
  endfunction

  function automatic int off_src_x(input int cw, input int lw);
    return cw + lw;
  endfunction

  function automatic int off_dest_y(input int cw, input int lw);
    return 2 * cw + lw;
  endfunction

  function automatic int off_dest_x(input int cw, input int lw);
    return 3 * cw + lw;
  endfunction

endpackage

// File: rtl/noc_credit_cnt.sv
// Credit counter for the router's local input buffer. Starts full, counts
// down on each send and up on each returned credit; a returned credit while
// already full saturates and raises a sticky error flag.
module noc_credit_cnt #(
  parameter int BUF_DEPTH = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic send,
  input  logic credit_in,
  output logic credit_avail,
  output logic credit_err
);

  localparam int CW = $clog2(BUF_DEPTH + 1);
  localparam logic [CW-1:0] FULL = CW'(BUF_DEPTH);

  logic [CW-1:0] cnt;

  // Count update; simultaneous send and credit cancel out
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt        <= FULL;
      credit_err <= 1'b0;
    end else if (send && !credit_in) begin
      cnt <= cnt - CW'(1);
    end else if (credit_in && !send) begin
      if (cnt == FULL) credit_err <= 1'b1;
      else             cnt        <= cnt + CW'(1);
    end
  end

  assign credit_avail = (cnt != '0);

endmodule

// File: rtl/noc_local_inject.sv
// Local injection port: turns packet requests plus payload words into
// head/body/tail flits for the router's local input, gated by credits.
// Optional per-port statistics counters under NOC_INJECT_STATS_EN.
module noc_local_inject
  import noc_pkg::*;
#(
  parameter int XCOORD    = 0,
  parameter int YCOORD    = 0,
  parameter int COORD_W   = 4,
  parameter int LEN_W     = 4,
  parameter int DATA_W    = 32,
  parameter int BUF_DEPTH = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [COORD_W-1:0] req_dest_x,
  input  logic [COORD_W-1:0] req_dest_y,
  input  logic [LEN_W-1:0]   req_len,
  input  logic               dat_valid,
  output logic               dat_ready,
  input  logic [DATA_W-1:0]  dat_in,
  output logic               flit_valid,
  output logic [1:0]         flit_type,
  output logic [DATA_W-1:0]  flit_out,
  input  logic               credit_in,
  output logic               busy,
  output logic               credit_err
`ifdef NOC_INJECT_STATS_EN
  ,
  output logic [15:0]        pkt_sent_cnt,
  output logic [15:0]        flit_sent_cnt
`endif
);

  localparam int OFF_DX = off_dest_x(COORD_W, LEN_W);
  localparam int OFF_DY = off_dest_y(COORD_W, LEN_W);
  localparam int OFF_SX = off_src_x(COORD_W, LEN_W);
  localparam int OFF_SY = off_src_y(COORD_W, LEN_W);
  localparam int OFF_LN = off_len(COORD_W, LEN_W);
  localparam logic [COORD_W-1:0] SRC_X = COORD_W'(XCOORD);
  localparam logic [COORD_W-1:0] SRC_Y = COORD_W'(YCOORD);

  if (DATA_W < hdr_w(COORD_W, LEN_W)) begin : g_width_chk
    $error("noc_local_inject: DATA_W too narrow for head flit fields");
  end

  typedef struct packed {
    logic [COORD_W-1:0] dx;
    logic [COORD_W-1:0] dy;
    logic [LEN_W-1:0]   len;
  } req_t;

  inj_state_t        state_q, state_d;
  req_t              req_q;
  logic [LEN_W-1:0]  rem_q;
  logic              credit_avail;
  logic              send;
  flit_type_t        type_d, type_q;
  logic [DATA_W-1:0] data_d;
  logic [DATA_W-1:0] head_word;

  // Assemble the head flit from the latched request and node coordinates
  always_comb begin
    head_word                    = '0;
    head_word[OFF_DX +: COORD_W] = req_q.dx;
    head_word[OFF_DY +: COORD_W] = req_q.dy;
    head_word[OFF_SX +: COORD_W] = SRC_X;
    head_word[OFF_SY +: COORD_W] = SRC_Y;
    head_word[OFF_LN +: LEN_W]   = req_q.len;
  end

  // Next state, handshakes and the flit to register this cycle
  always_comb begin
    state_d   = state_q;
    req_ready = 1'b0;
    dat_ready = 1'b0;
    send      = 1'b0;
    type_d    = FT_BODY;
    data_d    = dat_in;
    case (state_q)
      ST_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_d = ST_HEAD;
      end
      ST_HEAD: begin
        if (credit_avail) begin
          send    = 1'b1;
          data_d  = head_word;
          type_d  = (req_q.len != '0) ? FT_HEAD : FT_HEAD_TAIL;
          state_d = (req_q.len != '0) ? ST_BODY : ST_IDLE;
        end
      end
      ST_BODY: begin
        dat_ready = credit_avail;
        if (dat_valid && credit_avail) begin
          send = 1'b1;
          if (rem_q == LEN_W'(1)) begin
            type_d  = FT_TAIL;
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State, latched request and remaining payload count
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      req_q   <= '0;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == ST_IDLE && req_valid) begin
        req_q <= '{dx: req_dest_x, dy: req_dest_y, len: req_len};
        rem_q <= req_len;
      end else if (send && state_q == ST_BODY) begin
        rem_q <= rem_q - LEN_W'(1);
      end
    end
  end

  // Registered flit outputs; payload/type hold when nothing is sent
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flit_valid <= 1'b0;
      type_q     <= FT_BODY;
      flit_out   <= '0;
    end else begin
      flit_valid <= send;
      if (send) begin
        type_q   <= type_d;
        flit_out <= data_d;
      end
    end
  end

  assign flit_type = type_q;
  assign busy      = (state_q != ST_IDLE);

  noc_credit_cnt #(.BUF_DEPTH(BUF_DEPTH)) u_cred (
    .clk          (clk),
    .rst_n        (rst_n),
    .send         (send),
    .credit_in    (credit_in),
    .credit_avail (credit_avail),
    .credit_err   (credit_err)
  );

`ifdef NOC_INJECT_STATS_EN
  // Packet and flit counters, wrapping at 2^16
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pkt_sent_cnt  <= '0;
      flit_sent_cnt <= '0;
    end else if (send) begin
      flit_sent_cnt <= flit_sent_cnt + 16'd1;
      if (type_d == FT_TAIL || type_d == FT_HEAD_TAIL)
        pkt_sent_cnt <= pkt_sent_cnt + 16'd1;
    end
  end
`endif

endmodule
